calc_seq_ctrl: RTL and testbench

//  Sequencer for the calculator datapath. Drives the enables of the operand-A, operand-B,

---
 rtl/calc_seq_ctrl_pkg.sv | 21 ++
 rtl/calc_seq_ctrl_if.sv | 32 +++
 rtl/calc_tmo_cnt.sv | 31 +++
 rtl/calc_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_calc_seq_ctrl.sv | 132 +++++++++++++
 5 files changed

// File: rtl/calc_seq_ctrl_pkg.sv
// calc_seq_ctrl_pkg
//   Shared encodings for the calculator sequencer: FSM state codes (3-bit)
//   and the 2-bit error codes reported on err.
package calc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_WRITE   = 3'd4,
    S_HOLD    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_TMO   = 2'b01,
    ERR_ABORT = 2'b10
  } err_t;

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if
//   Bundles the sequencer's handshake and datapath-control signals.
//   master : the sequencer (drives in_ready, ld_*, alu_start, out_valid, busy, err)
//   slave  : front-end / ALU / display side (drives in_valid, abort, alu_done, out_ready)
interface calc_seq_ctrl_if;
  import calc_seq_ctrl_pkg::*;

  logic in_valid;
  logic in_ready;
  logic abort;
  logic ld_a;
  logic ld_b;
  logic ld_op;
  logic alu_start;
  logic alu_done;
  logic ld_res;
  logic out_valid;
  logic out_ready;
  logic busy;
  err_t err;

  modport master (
    input  in_valid, abort, alu_done, out_ready,
    output in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, out_valid, busy, err
  );

  modport slave (
    output in_valid, abort, alu_done, out_ready,
    input  in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, out_valid, busy, err
  );

endinterface

// File: rtl/calc_tmo_cnt.sv
// calc_tmo_cnt
//   ALU timeout counter. Cleared by clr, counts up on en, saturates at
//   TMO_CYC-1 and never wraps.
//   clk, rst : clock, synchronous active-high reset
//   clr      : restart count at 0
//   en       : count this cycle
//   term     : count has reached TMO_CYC-1
module calc_tmo_cnt #(
  parameter int unsigned TMO_CYC = 200,
  parameter int unsigned TMO_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [TMO_W-1:0] cnt;

  assign term = (cnt == TMO_W'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl
//   Sequencer for the calculator datapath: collects operand A, operand B and
//   opcode tokens, starts the multi-cycle ALU, loads the result and holds it
//   until the display side consumes it.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : calc_seq_ctrl_if.master (token handshake, register enables,
//              ALU start/done, result handshake, busy, err)
module calc_seq_ctrl
  import calc_seq_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYC = 200,
  parameter int unsigned TMO_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  calc_seq_ctrl_if.master bus
);

  state_t state, state_nx;
  err_t   err_q, err_nx;
  logic   ov_q, ov_nx;
  logic   first_q;
  logic   cnt_clr, cnt_en, tmo_term;
  logic   in_ready, ld_a, ld_b, ld_op, alu_start, ld_res;

  calc_tmo_cnt #(
    .TMO_CYC (TMO_CYC),
    .TMO_W   (TMO_W)
  ) u_tmo (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (tmo_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      err_q   <= ERR_NONE;
      ov_q    <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state   <= state_nx;
      err_q   <= err_nx;
      ov_q    <= ov_nx;
      // Opcode acceptance marks the next cycle as the first EXEC cycle.
      first_q <= ld_op;
    end
  end

  always_comb begin
    state_nx  = state;
    err_nx    = err_q;
    ov_nx     = ov_q;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    alu_start = 1'b0;
    ld_res    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    in_ready  = (state == S_IDLE) || (state == S_WAIT_B) || (state == S_WAIT_OP);

    if (bus.abort && (state != S_IDLE)) begin
      // Abort overrides every other input; no enable or start fires.
      state_nx = S_IDLE;
      err_nx   = ERR_ABORT;
      ov_nx    = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          ld_a     = 1'b1;
          err_nx   = ERR_NONE;
          state_nx = S_WAIT_B;
        end
        S_WAIT_B: if (bus.in_valid) begin
          ld_b     = 1'b1;
          state_nx = S_WAIT_OP;
        end
        S_WAIT_OP: if (bus.in_valid) begin
          ld_op    = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = S_EXEC;
        end
        S_EXEC: begin
          cnt_en    = 1'b1;
          alu_start = first_q;
          // Done takes priority over a timeout in the same cycle.
          if (bus.alu_done) begin
            ld_res   = 1'b1;
            state_nx = S_WRITE;
          end else if (tmo_term) begin
            err_nx   = ERR_TMO;
            state_nx = S_IDLE;
          end
        end
        S_WRITE: begin
          ov_nx    = 1'b1;
          state_nx = S_HOLD;
        end
        S_HOLD: if (bus.out_ready) begin
          ov_nx    = 1'b0;
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end

    // Reset wins: no register enable or ALU start while rst is high.
    if (rst) begin
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      ld_op     = 1'b0;
      alu_start = 1'b0;
      ld_res    = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.ld_a      = ld_a;
  assign bus.ld_b      = ld_b;
  assign bus.ld_op     = ld_op;
  assign bus.alu_start = alu_start;
  assign bus.ld_res    = ld_res;
  assign bus.out_valid = ov_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl
//   Directed-vector bench for calc_seq_ctrl (TMO_CYC=4). Each vector drives
//   {rst, in_valid, abort, alu_done, out_ready} for one cycle and compares the
//   output bundle {in_ready, ld_a, ld_b, ld_op, alu_start, ld_res, out_valid,
//   busy, err[1:0]} against a hand-computed value.
module tb_calc_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  calc_seq_ctrl_if bus ();

  calc_seq_ctrl #(
    .TMO_CYC (4),
    .TMO_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.in_ready, bus.ld_a, bus.ld_b, bus.ld_op, bus.alu_start,
            bus.ld_res, bus.out_valid, bus.busy, bus.err};
  endfunction

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // stim = {rst, in_valid, abort, alu_done, out_ready}
  // exp  = {in_ready}_{ld_a ld_b ld_op}_{alu_start ld_res}_{out_valid busy}_{err}
  task automatic vec(input string tag, input logic [4:0] stim, input logic [9:0] exp);
    {rst, bus.in_valid, bus.abort, bus.alu_done, bus.out_ready} = stim;
    #1;
    chk(tag, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.abort     = 1'b0;
    bus.alu_done  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state (second reset cycle)
    vec("rst_state",   5'b1_0000, 10'b1_000_00_00_00);

    // 1 Nominal: 7, 5, ADD; done 3 cycles after start; out_ready 2 after out_valid
    vec("n_tokA",      5'b0_1000, 10'b1_100_00_00_00);
    vec("n_tokB",      5'b0_1000, 10'b1_010_00_01_00);
    vec("n_tokOP",     5'b0_1000, 10'b1_001_00_01_00);
    vec("n_exec1",     5'b0_0000, 10'b0_000_10_01_00);
    vec("n_exec2",     5'b0_0000, 10'b0_000_00_01_00);
    vec("n_exec3",     5'b0_0000, 10'b0_000_00_01_00);
    vec("n_done",      5'b0_0010, 10'b0_000_01_01_00);
    vec("n_write",     5'b0_0000, 10'b0_000_00_01_00);
    vec("n_hold0",     5'b0_0000, 10'b0_000_00_11_00);
    vec("n_hold1",     5'b0_0000, 10'b0_000_00_11_00);
    vec("n_hold2",     5'b0_0001, 10'b0_000_00_11_00);
    vec("n_idle",      5'b0_0000, 10'b1_000_00_00_00);

    // 2 Backpressure: in_valid held high through EXEC/WRITE/HOLD
    vec("bp_tokA",     5'b0_1000, 10'b1_100_00_00_00);
    vec("bp_tokB",     5'b0_1000, 10'b1_010_00_01_00);
    vec("bp_tokOP",    5'b0_1000, 10'b1_001_00_01_00);
    vec("bp_exec1",    5'b0_1000, 10'b0_000_10_01_00);
    vec("bp_done",     5'b0_1010, 10'b0_000_01_01_00);
    vec("bp_write",    5'b0_1000, 10'b0_000_00_01_00);
    vec("bp_hold",     5'b0_1001, 10'b0_000_00_11_00);
    vec("bp_newtok",   5'b0_1000, 10'b1_100_00_00_00);
    vec("bp_abort_b",  5'b0_0100, 10'b1_000_00_01_00);
    vec("bp_err_abt",  5'b0_0000, 10'b1_000_00_00_10);
    vec("idle_abort",  5'b0_0100, 10'b1_000_00_00_10);
    vec("idle_errkp",  5'b0_0000, 10'b1_000_00_00_10);

    // 3 Timeout: alu_done never asserted
    vec("t_tokA",      5'b0_1000, 10'b1_100_00_00_10);
    vec("t_tokB",      5'b0_1000, 10'b1_010_00_01_00);
    vec("t_tokOP",     5'b0_1000, 10'b1_001_00_01_00);
    vec("t_exec1",     5'b0_0000, 10'b0_000_10_01_00);
    vec("t_exec2",     5'b0_0000, 10'b0_000_00_01_00);
    vec("t_exec3",     5'b0_0000, 10'b0_000_00_01_00);
    vec("t_exec4",     5'b0_0000, 10'b0_000_00_01_00);
    vec("t_idle_err",  5'b0_0000, 10'b1_000_00_00_01);
    vec("t_ign_done",  5'b0_0011, 10'b1_000_00_00_01);
    vec("t_still",     5'b0_0000, 10'b1_000_00_00_01);

    // 4 Boundary: alu_done in the 4th EXEC cycle; then abort in HOLD with out_ready
    vec("b_tokA",      5'b0_1000, 10'b1_100_00_00_01);
    vec("b_tokB",      5'b0_1000, 10'b1_010_00_01_00);
    vec("b_tokOP",     5'b0_1000, 10'b1_001_00_01_00);
    vec("b_exec1",     5'b0_0000, 10'b0_000_10_01_00);
    vec("b_exec2",     5'b0_0000, 10'b0_000_00_01_00);
    vec("b_exec3",     5'b0_0000, 10'b0_000_00_01_00);
    vec("b_exec4_dn",  5'b0_0010, 10'b0_000_01_01_00);
    vec("b_write",     5'b0_0000, 10'b0_000_00_01_00);
    vec("b_hold",      5'b0_0000, 10'b0_000_00_11_00);
    vec("a_hold_abt",  5'b0_0101, 10'b0_000_00_11_00);
    vec("a_hold_idle", 5'b0_0000, 10'b1_000_00_00_10);

    // 5 Abort in WAIT_OP together with in_valid
    vec("a_tokA",      5'b0_1000, 10'b1_100_00_00_10);
    vec("a_tokB",      5'b0_1000, 10'b1_010_00_01_00);
    vec("a_wop_abt",   5'b0_1100, 10'b1_000_00_01_00);
    vec("a_wop_idle",  5'b0_0000, 10'b1_000_00_00_10);

    // 6 Reset in the same cycle as alu_done
    vec("r_tokA",      5'b0_1000, 10'b1_100_00_00_10);
    vec("r_tokB",      5'b0_1000, 10'b1_010_00_01_00);
    vec("r_tokOP",     5'b0_1000, 10'b1_001_00_01_00);
    vec("r_exec1",     5'b0_0000, 10'b0_000_10_01_00);
    vec("r_rst_done",  5'b1_0010, 10'b0_000_00_01_00);
    vec("r_idle",      5'b0_0000, 10'b1_000_00_00_00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
